encap_head: RTL and testbench
=============================

# encap_head

Header-insertion stage for the parser's slice-stream datapath. It is the transmit-side counterpart of head decapsulation. A configurable number of encap bytes are prepended to each packet, every following byte is realigned by that amount, and the packet's metadata is attached to the first output slice. The block sits between the deparser's header builder and the packet output FIFO, and emits an extra tail slice when the realigned packet overflows.

## Interface
- HEAD_WIDTH, 128: slice data width in bits. B = HEAD_WIDTH/8 bytes per slice.
- TAG_WIDTH, 8: tag width. Tag bit 0 is valid, 1 is start, 2 is tail, 3 is shift, [7:4] is the tail byte count (0 means B bytes).
- META_WIDTH, 64: metadata width.
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_head  in  HEAD_WIDTH+TAG_WIDTH  input slice. Data occupies [HEAD_WIDTH-1:0], with byte 0 in the most-significant bits; the tag occupies the upper bits.
- o_ready  out  1  high when an input slice may be presented
- i_encapData  in  HEAD_WIDTH  encap bytes, left-aligned (byte 0 in the MSBs); sampled on the start slice
- i_encapLen  in  $clog2(B)  number of encap bytes L, range 0..B-1; sampled on the start slice
- i_meta  in  META_WIDTH  packet metadata; sampled on the start slice
- o_head  out  HEAD_WIDTH+TAG_WIDTH  output slice, same format as i_head
- o_meta  out  META_WIDTH  metadata; valid only alongside an output start slice, zero otherwise

## Operation
- A slice is accepted when tag.valid=1 and o_ready=1. A valid slice presented while o_ready=0 is discarded and has no effect.
- At reset, all outputs and state clear: o_head=0, o_meta=0, state IDLE, o_ready=1.
- The block has three states: IDLE, BODY and EXTRA.
- **IDLE.** An accepted slice with start=1 latches L, i_encapData and i_meta.
  - Output slice 0 is the L encap bytes followed by the first B-L bytes of input slice 0.
  - It is emitted with start=1 and o_meta equal to the latched meta.
  - The last L bytes of input slice 0 are held as the residual.
  - Next state is BODY, or the tail handling below if the same slice has tail=1.
  - A valid slice without start in IDLE is discarded.
- **BODY.** Each accepted slice k produces an output of the residual (L bytes) followed by the first B-L bytes of slice k. The residual is then updated.
  - A start=1 slice in BODY abandons the current packet (no tail is emitted for it) and is processed as an IDLE start.
- **Tail.** For an input tail slice with n valid bytes (tag[7:4], where 0 means B):
  - If n+L <= B, the output slice carries tail=1 and count (n+L) mod B. Next state is IDLE.
  - If n+L > B, the output slice is full with tail=0. Next state is EXTRA.
- **EXTRA.** The block emits one slice holding the remaining n+L-B residual bytes, left-aligned, with tail=1 and count n+L-B.
  - o_ready=0 for this cycle.
  - Next state is IDLE.
- **Output tag fields.**
  - valid=1 on every emitted slice.
  - shift is always 0.
  - start appears only on output slice 0.
  - The count field is 0 on non-tail slices.
- Output data bytes beyond the count on a tail slice are 0.
- When L=0, the block is a pure one-cycle passthrough and EXTRA is never entered.

## Timing
- All outputs are registered. An output slice appears in the cycle after the accepting edge of its input slice, so latency is 1 cycle.
- An EXTRA slice appears 1 cycle after the output tail-overflow slice, i.e. 2 cycles after the input tail slice.
- o_ready is combinational from state. It is low exactly during the EXTRA state cycle.
- In cycles with no emission, o_head tag.valid=0 and o_head data is 0.
- Back-to-back packets are supported: a start slice may be accepted in the cycle right after a tail, unless EXTRA is pending.
- If reset asserts mid-packet, outputs clear asynchronously, the packet is lost, and the block resumes in IDLE.

## Test plan
- **L=0 passthrough.** Send a 3-slice packet with tail count 5 and meta 0xA5. Required: identical slices 1 cycle later, start on the first, o_meta=0xA5 only with start, tail count 5.
- **L=4 without overflow.** Send a 2-slice packet (tail n=10). Required: out0 = encap[0..3] followed by in0[0..11]; out1 = in0[12..15] followed by in1[0..9], with tail=1 and count 14. o_ready stays 1.
- **L=6 with overflow.** Send a single-slice packet with start and tail both set, n=0 (16 bytes). Required: out0 is full with tail=0; the next cycle emits 6 bytes with tail=1 and count 6. o_ready=0 in that cycle, and a valid slice presented then is discarded.
- **Back-to-back packets.** Send packet A (L=2, n=3), then packet B's start in the next cycle. Required: B's out0 follows A's tail with no gap, and B's L and meta are latched independently.
- **Abort and reset.** Send a start while in BODY. Required: the old packet stops without a tail and the new packet starts correctly. Separately, assert i_rst_n low mid-packet. Required: o_head=0 and o_meta=0 immediately, o_ready=1, and a non-start slice after reset is discarded.

Source files
------------

// File: rtl/encap_head.sv
// Header-insertion stage: prepends 0..B-1 encap bytes to each packet on the slice
// stream, realigns the body by that amount and spills an extra tail slice on overflow.
module encap_head #(
    parameter int HEAD_WIDTH = 128,
    parameter int TAG_WIDTH  = 8,
    parameter int META_WIDTH = 64
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [HEAD_WIDTH+TAG_WIDTH-1:0] i_head,
    output logic                            o_ready,
    input  logic [HEAD_WIDTH-1:0]           i_encapData,
    input  logic [$clog2(HEAD_WIDTH/8)-1:0] i_encapLen,
    input  logic [META_WIDTH-1:0]           i_meta,
    output logic [HEAD_WIDTH+TAG_WIDTH-1:0] o_head,
    output logic [META_WIDTH-1:0]           o_meta,
    output logic [1:0]                      o_dbg_state
);
    localparam int B  = HEAD_WIDTH / 8;
    localparam int LW = $clog2(B);
    localparam int CW = LW + 1;
    localparam int SW = $clog2(HEAD_WIDTH) + 1;

    // Handshake: a slice moves when its tag.valid is high and o_ready is high in the
    // same cycle; a valid slice seen while o_ready is low is dropped, never stalled.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BODY  = 2'd1,
        S_EXTRA = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic [LW-1:0]                   len_q, len_d;
    logic [HEAD_WIDTH-1:0]           resid_q, resid_d;
    logic [LW-1:0]                   xcnt_q, xcnt_d;
    logic [HEAD_WIDTH+TAG_WIDTH-1:0] head_d;
    logic [META_WIDTH-1:0]           meta_d;

    logic [HEAD_WIDTH-1:0] in_data;
    logic                  in_valid, in_start, in_tail;
    logic [LW-1:0]         in_cnt;
    logic                  unused_shift;

    logic                  accept, take_start, take_body;
    logic [LW-1:0]         cur_len;
    logic [CW-1:0]         n_bytes, total;
    logic [SW-1:0]         sh_len, sh_rem, sh_keep;
    logic [HEAD_WIDTH-1:0] in_m, lead, out_data;

    function automatic logic [TAG_WIDTH-1:0] make_tag(input logic start, input logic tail,
                                                      input logic [LW-1:0] cnt);
        return TAG_WIDTH'({cnt, 1'b0, tail, start, 1'b1});
    endfunction

    assign in_data      = i_head[HEAD_WIDTH-1:0];
    assign in_valid     = i_head[HEAD_WIDTH];
    assign in_start     = i_head[HEAD_WIDTH+1];
    assign in_tail      = i_head[HEAD_WIDTH+2];
    assign unused_shift = i_head[HEAD_WIDTH+3];
    assign in_cnt       = i_head[HEAD_WIDTH+4 +: LW];

    assign o_ready     = (state_q != S_EXTRA);
    assign o_dbg_state = state_q;

    assign accept     = in_valid && o_ready;
    assign take_start = accept && in_start;
    assign take_body  = accept && !in_start && (state_q == S_BODY);

    // A start slice uses the length arriving with it, not the one from the last packet.
    assign cur_len = take_start ? i_encapLen : len_q;
    assign n_bytes = (in_cnt == '0) ? CW'(B) : CW'(in_cnt);
    assign total   = n_bytes + CW'(cur_len);
    assign sh_len  = SW'(cur_len) << 3;
    assign sh_rem  = (SW'(B) - SW'(cur_len)) << 3;
    assign sh_keep = SW'(n_bytes) << 3;

    // Bytes past the tail count are zeroed before realignment so they never leak out.
    assign in_m     = in_tail ? (in_data & ~({HEAD_WIDTH{1'b1}} >> sh_keep)) : in_data;
    assign lead     = take_start ? (i_encapData & ~({HEAD_WIDTH{1'b1}} >> sh_len)) : resid_q;
    assign out_data = lead | (in_m >> sh_len);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        resid_d = resid_q;
        xcnt_d  = xcnt_q;
        head_d  = '0;
        meta_d  = '0;
        case (state_q)
            S_EXTRA: begin
                head_d  = {make_tag(1'b0, 1'b1, xcnt_q), resid_q};
                resid_d = '0;
                xcnt_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                if (take_start || take_body) begin
                    len_d   = cur_len;
                    resid_d = in_m << sh_rem;
                    if (take_start) begin
                        meta_d = i_meta;
                    end
                    if (!in_tail) begin
                        head_d  = {make_tag(take_start, 1'b0, '0), out_data};
                        state_d = S_BODY;
                    end else if (total <= CW'(B)) begin
                        head_d  = {make_tag(take_start, 1'b1, total[LW-1:0]), out_data};
                        resid_d = '0;
                        state_d = S_IDLE;
                    end else begin
                        // Realigned tail overflows: emit it full now, the spill next cycle.
                        head_d  = {make_tag(take_start, 1'b0, '0), out_data};
                        xcnt_d  = LW'(total - CW'(B));
                        state_d = S_EXTRA;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            resid_q <= '0;
            xcnt_q  <= '0;
            o_head  <= '0;
            o_meta  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            resid_q <= resid_d;
            xcnt_q  <= xcnt_d;
            o_head  <= head_d;
            o_meta  <= meta_d;
        end
    end
endmodule

// File: tb/tb_encap_head.sv
// Bench for encap_head: packets from a vector table plus abort, overflow and reset
// sequences, compared against a byte-stream model through an expected-output queue.
`timescale 1ns/1ps
module tb_encap_head;
    localparam int HW = 128;
    localparam int TW = 8;
    localparam int MW = 64;
    localparam int B  = 16;
    localparam int SW = HW + TW;
    localparam int EW = MW + SW;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b1;
    logic [SW-1:0] i_head;
    logic          o_ready;
    logic [HW-1:0] i_encapData;
    logic [3:0]    i_encapLen;
    logic [MW-1:0] i_meta;
    logic [SW-1:0] o_head;
    logic [MW-1:0] o_meta;
    logic [1:0]    o_dbg_state;

    encap_head #(.HEAD_WIDTH(HW), .TAG_WIDTH(TW), .META_WIDTH(MW)) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_head(i_head),
        .o_ready(o_ready),
        .i_encapData(i_encapData),
        .i_encapLen(i_encapLen),
        .i_meta(i_meta),
        .o_head(o_head),
        .o_meta(o_meta),
        .o_dbg_state(o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int              checks = 0;
    int              errors = 0;
    int              out_cnt = 0;
    int              last_tail_cnt = -1;
    logic [EW-1:0]   exp_q[$];

    typedef struct {
        int            len;
        int            nsl;
        int            n;
        logic [MW-1:0] meta;
        bit            b2b;
        int            exp_nout;
        int            exp_last;
    } vec_t;

    vec_t tbl[11];

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic check_vec(input string name, input logic [EW-1:0] got, input logic [EW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic logic [HW-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Output monitor, sampled on the falling edge.
    always @(negedge i_clk) begin
        logic [EW-1:0] exp;
        if (o_head[HW] === 1'b1) begin
            out_cnt++;
            if (o_head[HW+2] === 1'b1) last_tail_cnt = int'(o_head[HW+4 +: 4]);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out got=%h want=none", {o_meta, o_head});
            end else begin
                exp = exp_q.pop_front();
                if ({o_meta, o_head} !== exp) begin
                    errors++;
                    $display("FAIL out_slice got=%h want=%h", {o_meta, o_head}, exp);
                end
            end
        end else begin
            checks++;
            if ({o_meta, o_head} !== '0) begin
                errors++;
                $display("FAIL idle_zero got=%h want=0", {o_meta, o_head});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_slice(input logic [SW-1:0] h, input logic [HW-1:0] e,
                               input logic [3:0] l, input logic [MW-1:0] m);
        int guard = 0;
        while (o_ready !== 1'b1 && guard < 8) begin
            i_head = '0;
            @(posedge i_clk); #1;
            guard++;
        end
        if (o_ready !== 1'b1) check_int("ready_wait", int'(o_ready), 1);
        i_head      = h;
        i_encapData = e;
        i_encapLen  = l;
        i_meta      = m;
        @(posedge i_clk); #1;
    endtask

    // Builds the expected output from the concatenated byte stream, then drives the
    // first nsend input slices (nsend < nsl leaves the packet unfinished).
    task automatic send_pkt(input int len, input int nsl, input int n,
                            input logic [MW-1:0] meta, input int nsend);
        byte unsigned  stream[$];
        logic [HW-1:0] enc;
        logic [HW-1:0] slc[4];
        logic [HW-1:0] d;
        logic [MW-1:0] m_exp;
        logic [TW-1:0] tag;
        logic [3:0]    cnt;
        int            nn, nout, nbytes, limit;
        logic          last;
        nn  = (n == 0) ? B : n;
        enc = rand128();
        for (int j = 0; j < len; j++) stream.push_back(enc[HW-1-8*j -: 8]);
        for (int k = 0; k < nsl; k++) begin
            slc[k] = rand128();
            nbytes = (k == nsl - 1) ? nn : B;
            for (int j = 0; j < nbytes; j++) stream.push_back(slc[k][HW-1-8*j -: 8]);
        end
        nout  = (stream.size() + B - 1) / B;
        limit = (nsend < nsl) ? nsend : nout;
        for (int i = 0; i < limit; i++) begin
            d = '0;
            for (int j = 0; j < B; j++)
                if (i * B + j < stream.size()) d[HW-1-8*j -: 8] = stream[i*B+j];
            last  = (i == nout - 1);
            cnt   = last ? 4'(stream.size() % B) : 4'd0;
            tag   = {cnt, 1'b0, last, (i == 0), 1'b1};
            m_exp = (i == 0) ? meta : '0;
            exp_q.push_back({m_exp, tag, d});
        end
        for (int k = 0; k < nsend; k++) begin
            cnt = (k == nsl - 1) ? 4'(n) : 4'd0;
            tag = {cnt, 1'($urandom_range(0, 1)), (k == nsl - 1), (k == 0), 1'b1};
            if (k == 0) drive_slice({tag, slc[k]}, enc, 4'(len), meta);
            else drive_slice({tag, slc[k]}, rand128(), 4'($urandom_range(0, 15)),
                             {$urandom, $urandom});
        end
        if (nsend == nsl) check_int("latency_valid", int'(o_head[HW]), 1);
    endtask

    task automatic drain();
        int guard = 0;
        i_head = '0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(posedge i_clk); #1;
            guard++;
        end
        repeat (2) begin
            @(posedge i_clk); #1;
        end
        check_int("drain_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int base, acc;
        //          len nsl  n  meta        b2b nout last
        tbl[0]  = '{0,  3,  5, 64'hA5,     1'b0, 3,  5};
        tbl[1]  = '{4,  2, 10, 64'h1111,   1'b0, 2, 14};
        tbl[2]  = '{6,  1,  0, 64'h2222,   1'b0, 2,  6};
        tbl[3]  = '{2,  1,  3, 64'hAAAA,   1'b1, 1,  5};
        tbl[4]  = '{9,  2,  7, 64'hBBBB,   1'b0, 2,  0};
        tbl[5]  = '{15, 3,  0, 64'h3333,   1'b1, 4, 15};
        tbl[6]  = '{1,  1,  1, 64'h4444,   1'b0, 1,  2};
        tbl[7]  = '{3,  2, 13, 64'h5555,   1'b0, 2,  0};
        tbl[8]  = '{15, 1,  1, 64'h6666,   1'b0, 1,  0};
        tbl[9]  = '{0,  1,  0, 64'h7777,   1'b0, 1,  0};
        tbl[10] = '{12, 2,  9, 64'h8888,   1'b0, 3,  5};

        i_head      = '0;
        i_encapData = '0;
        i_encapLen  = '0;
        i_meta      = '0;
        #2 i_rst_n = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check_vec("reset_out", {o_meta, o_head}, '0);
        check_int("reset_ready", int'(o_ready), 1);
        check_int("reset_state", int'(o_dbg_state), 0);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        base = out_cnt;
        acc  = 0;
        for (int v = 0; v < 11; v++) begin
            send_pkt(tbl[v].len, tbl[v].nsl, tbl[v].n, tbl[v].meta, tbl[v].nsl);
            acc += tbl[v].exp_nout;
            if (!tbl[v].b2b) begin
                drain();
                check_int($sformatf("vec%0d_nout", v), out_cnt - base, acc);
                check_int($sformatf("vec%0d_last_cnt", v), last_tail_cnt, tbl[v].exp_last);
                base = out_cnt;
                acc  = 0;
            end
        end

        // Overflow spill cycle: ready drops and a start presented then is dropped.
        send_pkt(6, 1, 0, 64'hC0FFEE, 1);
        check_int("extra_ready", int'(o_ready), 0);
        check_int("extra_state", int'(o_dbg_state), 2);
        i_head      = {8'h07, rand128()};
        i_encapLen  = 4'd3;
        i_encapData = rand128();
        i_meta      = 64'hBAD0;
        @(posedge i_clk); #1;
        check_int("extra_tail_bit", int'(o_head[HW+2]), 1);
        check_int("after_extra_ready", int'(o_ready), 1);
        drain();
        check_int("extra_nout", out_cnt - base, 2);
        check_int("extra_last_cnt", last_tail_cnt, 6);
        base = out_cnt;

        // Start arriving mid-packet abandons the old packet without a tail.
        send_pkt(5, 3, 4, 64'hAB0A, 2);
        send_pkt(8, 2, 6, 64'hAB0B, 2);
        drain();
        check_int("abort_nout", out_cnt - base, 4);
        check_int("abort_last_cnt", last_tail_cnt, 14);

        // Asynchronous reset mid-packet.
        send_pkt(7, 3, 2, 64'hDEAD, 2);
        #1 i_rst_n = 1'b0;
        exp_q.delete();
        i_head = '0;
        #1;
        check_vec("midreset_out", {o_meta, o_head}, '0);
        check_int("midreset_ready", int'(o_ready), 1);
        check_int("midreset_state", int'(o_dbg_state), 0);
        @(negedge i_clk);
        #1 i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        base   = out_cnt;
        i_head = {8'h01, rand128()};
        @(posedge i_clk); #1;
        i_head = '0;
        check_int("nonstart_state", int'(o_dbg_state), 0);
        repeat (3) begin
            @(posedge i_clk); #1;
        end
        check_int("nonstart_dropped", out_cnt - base, 0);
        send_pkt(5, 1, 8, 64'hBEEF, 1);
        drain();
        check_int("resume_nout", out_cnt - base, 1);
        check_int("resume_last_cnt", last_tail_cnt, 13);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
